svm_seq_ctrl: RTL and testbench

// - Sequenced, resource-shared version of the 4-feature linear SVM classifier.
// - One signed multiplier and one accumulator are time-multiplexed over f1..f4, then the bias is added.
// - The sign of the score gives the class bit.
// - Sits between the feature-extraction front end and the decision consumer, using valid/ready on both sides.

---
 rtl/svm_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_svm_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// svm_seq_ctrl
// Sequenced, resource-shared 4-feature linear SVM classifier.
// A single signed multiplier and accumulator are stepped over f1..f4, one
// product per clock. The bias is then added, and the sign of the score gives
// the class bit. The block has valid/ready handshakes on the input side and on
// the output side.
//
// Optional feature (macro SVM_WCFG_EN): runtime programming of W1..W4 and B
// through the cfg_* port group. When the macro is undefined, the weights and
// bias are the fixed parameters and the cfg ports do not exist.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      feature vector valid
//   in_ready   out  1      vector can be accepted (IDLE only)
//   f1..f4     in   16/15/10/13  unsigned features
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      consumer accepts the result
//   class_out  out  1      1 when score >= 0
//   score      out  ACC_W  signed score = sum(Wi*fi) + B
//   busy       out  1      high in any state other than IDLE
//   cfg_we     in   1      (SVM_WCFG_EN) configuration write strobe
//   cfg_addr   in   3      (SVM_WCFG_EN) 0..3 = W1..W4, 4 = B
//   cfg_wdata  in   22     (SVM_WCFG_EN) write data, weights use [9:0]
//   cfg_err    out  1      (SVM_WCFG_EN) one-cycle pulse on a dropped write
//
// Timing: input accepted at edge T, MAC steps at T+1..T+4, bias at T+5, and
// out_valid is visible after T+5.
// -----------------------------------------------------------------------------
module svm_seq_ctrl #(
   parameter logic signed [9:0]  W1    = -10'sd37,
   parameter logic signed [9:0]  W2    = -10'sd1,
   parameter logic signed [9:0]  W3    = -10'sd233,
   parameter logic signed [9:0]  W4    = -10'sd423,
   parameter logic signed [21:0] B     = 22'sd131072,
   parameter int                 ACC_W = 30
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             f1,
   input  logic [14:0]             f2,
   input  logic [9:0]              f3,
   input  logic [12:0]             f4,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    class_out,
   output logic signed [ACC_W-1:0] score,
   output logic                    busy
`ifdef SVM_WCFG_EN
   ,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_addr,
   input  logic [21:0]             cfg_wdata,
   output logic                    cfg_err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      BIAS = 2'd2,
      DONE = 2'd3
   } state_t;

   // Packed copy of the weight parameters so a generate loop can index them.
   localparam logic [39:0] W_INIT = {W4, W3, W2, W1};

   state_t state_reg;
   state_t state_next;

   logic accept;
   logic mac_en;
   logic bias_en;
   logic out_ack;

   logic [1:0]              idx_reg;
   logic [15:0]             feat_reg [4];
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] score_reg;
   logic                    class_reg;
   logic                    out_valid_reg;

   logic signed [9:0]       w_arr [4];
   logic signed [21:0]      b_val;

   logic [15:0]             feat_sel;
   logic signed [9:0]       w_sel;
   logic signed [26:0]      product;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] sum;

   genvar gi;

   // ------------------------------------------------------------------------
   // Weight / bias source
   // ------------------------------------------------------------------------
`ifdef SVM_WCFG_EN
   logic cfg_ok;
   logic cfg_err_reg;
   logic signed [21:0] b_reg;

   // Writes are applied only while IDLE. A write that coincides with an
   // input accept lands on the same edge, so the new vector sees it.
   assign cfg_ok = cfg_we && (state_reg == IDLE) && (cfg_addr <= 3'd4);

   generate
      for (gi = 0; gi < 4; gi++) begin : g_wcfg
         logic signed [9:0] w_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               w_q <= $signed(W_INIT[gi*10 +: 10]);
            end else if (cfg_ok && (cfg_addr == 3'(gi))) begin
               w_q <= $signed(cfg_wdata[9:0]);
            end
         end
         assign w_arr[gi] = w_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_reg       <= B;
         cfg_err_reg <= 1'b0;
      end else begin
         if (cfg_ok && (cfg_addr == 3'd4)) begin
            b_reg <= $signed(cfg_wdata);
         end
         cfg_err_reg <= cfg_we && !cfg_ok;
      end
   end

   assign b_val   = b_reg;
   assign cfg_err = cfg_err_reg;
`else
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wfix
         assign w_arr[gi] = $signed(W_INIT[gi*10 +: 10]);
      end
   endgenerate

   assign b_val = B;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and datapath strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      mac_en     = 1'b0;
      bias_en    = 1'b0;
      out_ack    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (idx_reg == 2'd3) begin
               state_next = BIAS;
            end
         end
         BIAS: begin
            bias_en    = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            // No bypass: the return to IDLE costs a cycle before the next
            // vector can be taken.
            if (out_ready) begin
               out_ack    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Shared multiplier and accumulator
   // ------------------------------------------------------------------------
   always_comb begin
      feat_sel = feat_reg[idx_reg];
      w_sel    = w_arr[idx_reg];
      // The zero-extended 17-bit feature times a 10-bit weight fits in 27 bits.
      product  = $signed({1'b0, feat_sel}) * w_sel;
      acc_next = acc_reg + $signed({{(ACC_W-27){product[26]}}, product});
      sum      = acc_reg + $signed({{(ACC_W-22){b_val[21]}}, b_val});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg       <= 2'd0;
         acc_reg       <= '0;
         score_reg     <= '0;
         class_reg     <= 1'b0;
         out_valid_reg <= 1'b0;
         feat_reg[0]   <= '0;
         feat_reg[1]   <= '0;
         feat_reg[2]   <= '0;
         feat_reg[3]   <= '0;
      end else begin
         if (accept) begin
            feat_reg[0] <= f1;
            feat_reg[1] <= {1'b0, f2};
            feat_reg[2] <= {6'd0, f3};
            feat_reg[3] <= {3'd0, f4};
            acc_reg     <= '0;
            idx_reg     <= 2'd0;
         end
         if (mac_en) begin
            acc_reg <= acc_next;
            idx_reg <= idx_reg + 2'd1;   // wraps back to 0 after the 4th MAC
         end
         if (bias_en) begin
            score_reg     <= sum;
            class_reg     <= ~sum[ACC_W-1];
            out_valid_reg <= 1'b1;
         end
         if (out_ack) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = out_valid_reg;
   assign score     = score_reg;
   assign class_out = class_reg;

endmodule

// File: tb/tb_svm_seq_ctrl.sv
// Testbench for svm_seq_ctrl. The stimulus pushes expected results into a
// queue at each input accept, and a monitor pops and compares them on every
// output handshake.
module tb_svm_seq_ctrl;

   localparam int ACC_W = 30;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [15:0]             f1;
   logic [14:0]             f2;
   logic [9:0]              f3;
   logic [12:0]             f4;
   logic                    out_valid;
   logic                    out_ready;
   logic                    class_out;
   logic signed [ACC_W-1:0] score;
   logic                    busy;
`ifdef SVM_WCFG_EN
   logic                    cfg_we;
   logic [2:0]              cfg_addr;
   logic [21:0]             cfg_wdata;
   logic                    cfg_err;
`endif

   always #5 clk = ~clk;

   svm_seq_ctrl #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f1        (f1),
      .f2        (f2),
      .f3        (f3),
      .f4        (f4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .class_out (class_out),
      .score     (score),
      .busy      (busy)
`ifdef SVM_WCFG_EN
      ,
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err)
`endif
   );

   // Reference model state: the weights and bias currently in effect.
   longint w_m [4] = '{-37, -1, -233, -423};
   longint b_m     = 131072;

   typedef struct {
      longint score;
      longint cls;
   } exp_t;

   exp_t exp_q [$];
   int   total = 0;
   int   bad   = 0;
   int   n_txn = 0;

   function automatic longint model(input longint a, input longint b,
                                    input longint c, input longint d);
      return w_m[0]*a + w_m[1]*b + w_m[2]*c + w_m[3]*d + b_m;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: compares each completed output handshake with the scoreboard.
   exp_t e;
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got score=%0d, required no output", score);
         end else begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: score=%0d class=%0d expect score=%0d class=%0d",
                     n_txn, score, class_out, e.score, e.cls);
            check("score", longint'(score), e.score);
            check("class_out", longint'(class_out), e.cls);
         end
      end
   end

   // Offer a vector and wait for it to be accepted. The task returns 1 ns
   // after the accept edge, with the feature inputs scrambled.
   task automatic send(input logic [15:0] a, input logic [14:0] b,
                       input logic [9:0] c, input logic [12:0] d,
                       input bit expect_out);
      int n;
      exp_t x;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", longint'(in_ready), 1);
      f1 = a; f2 = b; f3 = c; f4 = d;
      in_valid = 1'b1;
      @(posedge clk);
      if (expect_out) begin
         x.score = model(longint'(a), longint'(b), longint'(c), longint'(d));
         x.cls   = (x.score >= 0) ? 1 : 0;
         exp_q.push_back(x);
      end
      #1;
      in_valid = 1'b0;
      f1 = 16'($urandom); f2 = 15'($urandom); f3 = 10'($urandom); f4 = 13'($urandom);
   endtask

   // Count negedges from the accept until out_valid is seen.
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
   endtask

   // Hold off the consumer for some cycles, then accept the result.
   task automatic consume(input int stall);
      repeat (stall) @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("in_ready_after_ack", longint'(in_ready), 1);
      check("busy_after_ack", longint'(busy), 0);
   endtask

   task automatic run_vec(input logic [15:0] a, input logic [14:0] b,
                          input logic [9:0] c, input logic [12:0] d);
      int lat;
      send(a, b, c, d, 1'b1);
      wait_out(lat);
      check("latency", longint'(lat), 6);
      check("in_ready_in_done", longint'(in_ready), 0);
      consume(int'($urandom_range(0, 2)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      longint es;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      f1 = '0; f2 = '0; f3 = '0; f4 = '0;
`ifdef SVM_WCFG_EN
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
`endif
      #23;
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_score", longint'(score), 0);
      check("rst_class", longint'(class_out), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, including the sign boundary.
      run_vec(16'd0, 15'd0, 10'd0, 13'd0);
      run_vec(16'd0, 15'd0, 10'd1023, 13'd0);
      run_vec(16'd65535, 15'd0, 10'd0, 13'd0);
      run_vec(16'd0, 15'd126, 10'd562, 13'd0);
      run_vec(16'd0, 15'd127, 10'd562, 13'd0);
      run_vec(16'd65535, 15'd32767, 10'd1023, 13'd8191);

      // Random vectors.
      for (int i = 0; i < 30; i++) begin
         run_vec(16'($urandom), 15'($urandom), 10'($urandom_range(0, 1023)),
                 13'($urandom));
      end

      // Consumer stalls for 10 cycles while in_valid is being waved at the DUT.
      send(16'd100, 15'd200, 10'd300, 13'd400, 1'b1);
      es = model(100, 200, 300, 400);
      wait_out(lat);
      check("stall_latency", longint'(lat), 6);
      for (int i = 0; i < 10; i++) begin
         check("stall_out_valid", longint'(out_valid), 1);
         check("stall_score", longint'(score), es);
         check("stall_class", longint'(class_out), (es >= 0) ? 1 : 0);
         check("stall_in_ready", longint'(in_ready), 0);
         in_valid = 1'b1;
         f1 = 16'($urandom); f2 = 15'($urandom); f3 = 10'($urandom); f4 = 13'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      consume(0);

      // Reset while the MAC is at idx=2. The pending result is discarded.
      send(16'd1000, 15'd1000, 10'd500, 13'd500, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", longint'(out_valid), 0);
      check("abort_busy", longint'(busy), 0);
      check("abort_in_ready", longint'(in_ready), 1);
      check("abort_score", longint'(score), 0);
      check("abort_class", longint'(class_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(16'd0, 15'd0, 10'd0, 13'd0);

`ifdef SVM_WCFG_EN
      // Write B=0 while IDLE.
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 22'd0;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      b_m = 0;
      check("cfg_err_ok", longint'(cfg_err), 0);
      run_vec(16'd0, 15'd0, 10'd0, 13'd0);
      // A write while busy is dropped and flagged.
      send(16'd5, 15'd6, 10'd7, 13'd8, 1'b1);
      cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 22'd5000;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      check("cfg_err_busy", longint'(cfg_err), 1);
      @(posedge clk);
      #1;
      check("cfg_err_pulse", longint'(cfg_err), 0);
      wait_out(lat);
      consume(0);
      run_vec(16'd0, 15'd0, 10'd0, 13'd0);
      // An address above 4 is dropped even in IDLE.
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 22'd77;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      check("cfg_err_addr", longint'(cfg_err), 1);
`endif

      repeat (5) @(negedge clk);
      check("queue_empty", longint'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
